// File: rtl/branch_target_buffer_if.sv
// Fetch/execute-side bundle for the branch target buffer: flush control,
// search request/response and resolved-branch update.
interface branch_target_buffer_if;
    logic        iFLUSH;
    logic        oBUSY;
    logic        iSEARCH_STB;
    logic [31:0] iSEARCH_INST_ADDR;
    logic        oSEARCH_VALID;
    logic        oSEARCH_HIT;
    logic        oSEARCH_PREDICT_TAKEN;
    logic [31:0] oSEARCH_ADDR;
    logic        iUPDATE_STB;
    logic        iUPDATE_TAKEN;
    logic [31:0] iUPDATE_INST_ADDR;
    logic [31:0] iUPDATE_ADDR;

    modport master (
        output iFLUSH, iSEARCH_STB, iSEARCH_INST_ADDR,
               iUPDATE_STB, iUPDATE_TAKEN, iUPDATE_INST_ADDR, iUPDATE_ADDR,
        input  oBUSY, oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_TAKEN, oSEARCH_ADDR
    );

    modport slave (
        input  iFLUSH, iSEARCH_STB, iSEARCH_INST_ADDR,
               iUPDATE_STB, iUPDATE_TAKEN, iUPDATE_INST_ADDR, iUPDATE_ADDR,
        output oBUSY, oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_TAKEN, oSEARCH_ADDR
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Set-associative BTB with 2-bit direction counters and true-LRU replacement.
// Optional MIST1032_BTB_UPDATE_BYPASS_EN forwards a same-address update into the search result.
module branch_target_buffer #(
    parameter int SET_ADDR_W = 4,
    parameter int WAY_W      = 1
) (
    input  logic iCLOCK,
    input  logic inRESET,
    branch_target_buffer_if.slave bus
);
    localparam int SET_N = 1 << SET_ADDR_W;
    localparam int WAY_N = 1 << WAY_W;
    localparam int TAG_W = 30 - SET_ADDR_W;
    localparam int AGE_W = (WAY_W == 0) ? 1 : WAY_W;

    typedef logic [AGE_W-1:0] age_t;
    typedef enum logic {IDLE, FLUSH} state_t;

    logic             valid_q  [SET_N][WAY_N];
    logic [TAG_W-1:0] tag_q    [SET_N][WAY_N];
    logic [1:0]       ctr_q    [SET_N][WAY_N];
    logic [31:0]      target_q [SET_N][WAY_N];
    age_t             age_q    [SET_N][WAY_N];

    state_t                state_q, state_d;
    logic [SET_ADDR_W-1:0] cnt_q, cnt_d;

    logic        res_valid_q, res_hit_q, res_taken_q;
    logic [31:0] res_addr_q;

    logic [SET_ADDR_W-1:0] s_set, u_set;
    logic [TAG_W-1:0]      s_tag, u_tag;
    logic                  s_hit, u_hit, s_touch, u_en, u_write, victim_found;
    age_t                  s_way, u_hit_way, u_victim, u_way;
    age_t                  s_age_new [WAY_N];
    age_t                  u_base_age [WAY_N];
    age_t                  u_age_new [WAY_N];
    logic [1:0]            u_ctr_new;
    logic [31:0]           u_target_new;
    logic                  r_hit, r_taken;
    logic [31:0]           r_addr;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.iSEARCH_INST_ADDR[1:0], bus.iUPDATE_INST_ADDR[1:0]};

    assign s_set = bus.iSEARCH_INST_ADDR[SET_ADDR_W+1:2];
    assign s_tag = bus.iSEARCH_INST_ADDR[31:SET_ADDR_W+2];
    assign u_set = bus.iUPDATE_INST_ADDR[SET_ADDR_W+1:2];
    assign u_tag = bus.iUPDATE_INST_ADDR[31:SET_ADDR_W+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.iFLUSH) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (bus.iFLUSH) begin
                    cnt_d = '0;
                end else if (cnt_q == SET_ADDR_W'(SET_N - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Search touches LRU first; the update then re-touches starting from those ages,
    // so on a shared set the update's ordering wins and its victim sees the search.
    always_comb begin
        s_hit        = 1'b0;
        s_way        = '0;
        u_hit        = 1'b0;
        u_hit_way    = '0;
        u_victim     = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAY_N; w++) begin
            if (valid_q[s_set][w] && tag_q[s_set][w] == s_tag) begin
                s_hit = 1'b1;
                s_way = age_t'(w);
            end
            if (valid_q[u_set][w] && tag_q[u_set][w] == u_tag) begin
                u_hit     = 1'b1;
                u_hit_way = age_t'(w);
            end
        end

        s_touch = bus.iSEARCH_STB && (state_q == IDLE) && s_hit;
        u_en    = bus.iUPDATE_STB && (state_q == IDLE) && !bus.iFLUSH;
        u_write = u_en && (u_hit || bus.iUPDATE_TAKEN);

        for (int w = 0; w < WAY_N; w++) begin
            if (age_t'(w) == s_way)
                s_age_new[w] = '0;
            else if (age_q[s_set][w] < age_q[s_set][s_way])
                s_age_new[w] = age_q[s_set][w] + 1'b1;
            else
                s_age_new[w] = age_q[s_set][w];
            u_base_age[w] = (s_touch && s_set == u_set) ? s_age_new[w] : age_q[u_set][w];
        end

        for (int w = 0; w < WAY_N; w++) begin
            if (!victim_found && !valid_q[u_set][w]) begin
                u_victim     = age_t'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAY_N; w++) begin
                if (u_base_age[w] == age_t'(WAY_N - 1))
                    u_victim = age_t'(w);
            end
        end
        u_way = u_hit ? u_hit_way : u_victim;

        for (int w = 0; w < WAY_N; w++) begin
            if (age_t'(w) == u_way)
                u_age_new[w] = '0;
            else if (u_base_age[w] < u_base_age[u_way])
                u_age_new[w] = u_base_age[w] + 1'b1;
            else
                u_age_new[w] = u_base_age[w];
        end

        if (!u_hit)
            u_ctr_new = 2'd2;
        else if (bus.iUPDATE_TAKEN)
            u_ctr_new = (ctr_q[u_set][u_way] == 2'd3) ? 2'd3 : ctr_q[u_set][u_way] + 2'd1;
        else
            u_ctr_new = (ctr_q[u_set][u_way] == 2'd0) ? 2'd0 : ctr_q[u_set][u_way] - 2'd1;
        u_target_new = bus.iUPDATE_TAKEN ? bus.iUPDATE_ADDR : target_q[u_set][u_way];

        r_hit   = s_hit;
        r_taken = ctr_q[s_set][s_way][1];
        r_addr  = target_q[s_set][s_way];
`ifdef MIST1032_BTB_UPDATE_BYPASS_EN
        if (u_write && bus.iSEARCH_INST_ADDR[31:2] == bus.iUPDATE_INST_ADDR[31:2]) begin
            r_hit   = 1'b1;
            r_taken = u_ctr_new[1];
            r_addr  = u_target_new;
        end
`endif
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int s = 0; s < SET_N; s++) begin
                for (int w = 0; w < WAY_N; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    ctr_q[s][w]    <= 2'd0;
                    target_q[s][w] <= '0;
                    age_q[s][w]    <= age_t'(w);
                end
            end
        end else if (state_q == FLUSH) begin
            for (int w = 0; w < WAY_N; w++) begin
                valid_q[cnt_q][w] <= 1'b0;
                age_q[cnt_q][w]   <= age_t'(w);
            end
        end else begin
            if (s_touch) begin
                for (int w = 0; w < WAY_N; w++)
                    age_q[s_set][w] <= s_age_new[w];
            end
            if (u_write) begin
                valid_q[u_set][u_way]  <= 1'b1;
                tag_q[u_set][u_way]    <= u_tag;
                ctr_q[u_set][u_way]    <= u_ctr_new;
                target_q[u_set][u_way] <= u_target_new;
                for (int w = 0; w < WAY_N; w++)
                    age_q[u_set][w] <= u_age_new[w];
            end
        end
    end

    // During a flush walk every search is answered as a miss.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_taken_q <= 1'b0;
            res_addr_q  <= '0;
        end else begin
            res_valid_q <= bus.iSEARCH_STB;
            if (state_q == IDLE && bus.iSEARCH_STB && r_hit) begin
                res_hit_q   <= 1'b1;
                res_taken_q <= r_taken;
                res_addr_q  <= r_addr;
            end else begin
                res_hit_q   <= 1'b0;
                res_taken_q <= 1'b0;
                res_addr_q  <= '0;
            end
        end
    end

    assign bus.oBUSY                 = (state_q == FLUSH);
    assign bus.oSEARCH_VALID         = res_valid_q;
    assign bus.oSEARCH_HIT           = res_hit_q;
    assign bus.oSEARCH_PREDICT_TAKEN = res_taken_q;
    assign bus.oSEARCH_ADDR          = res_addr_q;
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Set-associative branch target buffer with 2-bit saturating direction counters and true-LRU replacement, parametrised in set count and associativity. It sits in the fetch stage: fetch presents the instruction address and receives a registered target/direction prediction one cycle later. Execute writes back resolved branches through the update port. Flush is a multi-cycle set walk with a busy indication.

## Interface
Parameters:
- SET_ADDR_W, 4, log2 of set count; SET_N = 2^SET_ADDR_W (range 1..8)
- WAY_W, 1, log2 of way count; WAY_N = 2^WAY_W (range 0..2, i.e. 1..4 ways)
- Tag = inst_addr[31:SET_ADDR_W+2], width TAG_W = 30-SET_ADDR_W; bits [1:0] ignored

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  reset, asynchronous, active-low
- iFLUSH  in  1  start invalidate-all walk (pulse)
- oBUSY  out  1  flush walk in progress
- iSEARCH_STB  in  1  lookup request
- iSEARCH_INST_ADDR  in  32  fetch address
- oSEARCH_VALID  out  1  result valid (1 cycle after iSEARCH_STB)
- oSEARCH_HIT  out  1  tag hit in a valid way
- oSEARCH_PREDICT_TAKEN  out  1  hit way counter >= 2
- oSEARCH_ADDR  out  32  predicted target; 0 when !oSEARCH_HIT
- iUPDATE_STB  in  1  resolved branch write-back
- iUPDATE_TAKEN  in  1  branch was taken
- iUPDATE_INST_ADDR  in  32  branch instruction address
- iUPDATE_ADDR  in  32  resolved target

## Operation
- Per way per set: valid, tag[TAG_W], counter[2], target[32], age[WAY_W].
- Hit: valid && tag equal; at most one way hits (update never allocates a duplicate).
- Search: compare all ways of set iSEARCH_INST_ADDR[SET_ADDR_W+1:2]; on hit the hit way's age becomes 0 and every way with age < old age increments (true LRU). Miss: no state change.
- Update hit: counter +1 if taken (saturate 3), -1 if not taken (saturate 0); target overwritten if taken; LRU touched as above.
- Update miss, taken: allocate. Victim = lowest-index invalid way, else the way with age == WAY_N-1. Write valid=1, tag, target, counter=2, LRU touch.
- Update miss, not taken: no allocation, no state change.
- Same set searched and updated in one cycle: update's LRU touch applied last (takes priority); search result uses pre-update contents.
- State machine: IDLE -> FLUSH on iFLUSH; FLUSH clears valid and sets age=way index for set cnt, cnt increments, FLUSH -> IDLE after set SET_N-1. oBUSY=1 in FLUSH.
- During FLUSH: updates dropped; searches answered with oSEARCH_VALID=1, HIT=0, TAKEN=0, ADDR=0. iFLUSH in FLUSH restarts walk at set 0.
- iFLUSH and iUPDATE_STB same cycle: update dropped.
- Reset: all valid=0, counters=0, age=way index, state IDLE, cnt=0; reset mid-flush returns to IDLE fully cleared.

## Timing
- Search latency 1 cycle, registered outputs; back-to-back searches each cycle, fully pipelined.
- Update takes effect at clock edge; a search issued the cycle after an update sees it.
- Flush: iFLUSH at edge N -> oBUSY high N+1 .. N+SET_N; first normal update accepted at N+SET_N+1.
- Reset values: oBUSY=0, oSEARCH_VALID=0, oSEARCH_HIT=0, oSEARCH_PREDICT_TAKEN=0, oSEARCH_ADDR=0.

## Configuration
- MIST1032_BTB_UPDATE_BYPASS_EN defined: search and update same cycle with identical [31:2] address -> result reflects post-update entry (hit with new counter/target, or new allocation). Not-taken update to missing entry still returns miss.
- Undefined: search sees pre-update contents as stated above; no bypass logic.

## Test plan
- Reset, search 0x0000_1000 -> next cycle VALID=1, HIT=0, TAKEN=0, ADDR=0; oBUSY=0.
- Update 0x1000 taken target 0x2000, then search 0x1000 -> HIT=1, TAKEN=1, ADDR=0x2000; two not-taken updates -> counter 0, TAKEN=0, HIT=1.
- WAY_N=2, SET_ADDR_W=4: allocate 0x1000, 0x2000 (same set 0), search 0x1000, allocate 0x3000 -> 0x2000 evicted, 0x1000 and 0x3000 hit.
- Fill entries, iFLUSH -> oBUSY high exactly SET_N=16 cycles, searches during walk miss, update during walk then search after -> miss.
- Same-cycle update(0x4000 taken, 0x5000) and search 0x4000 on empty BTB -> HIT=0 without macro, HIT=1 ADDR=0x5000 with MIST1032_BTB_UPDATE_BYPASS_EN.
- Assert inRESET mid-flush (cnt=5) -> oBUSY=0 immediately, all entries invalid after release.
